// File: rtl/config.sv
// Shared mesh configuration: node counts, node-ID width and the packet
// format carried between traffic generators, interfaces and routers.
package config_pkg;

    localparam int X_NODES   = 4;
    localparam int Y_NODES   = 4;
    localparam int NODES     = X_NODES * Y_NODES;
    localparam int ID_W      = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int TS_W      = 16;
    localparam int PAYLOAD_W = 16;

    typedef struct packed {
        logic [ID_W-1:0]      src;
        logic [ID_W-1:0]      dest;
        logic [TS_W-1:0]      timestamp;
        logic [PAYLOAD_W-1:0] payload;
    } packet_t;

    localparam int PKT_W = $bits(packet_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding the injection queue of one node.
// Ports: clk, reset (sync, active-high), push/wr_data, pop, head, full, empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Occupancy comes from registers only, so a pop never frees a slot
    // for a push in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/node_interface.sv
// Network interface of one mesh node: stamps and queues generator packets
// for injection, and counts / times / checks packets ejected to this node.
// Ports: gen_* (generator side), net_* (router local input), ej_* (router
// local output), tx_count/rx_count/lat_sum statistics, err_dest sticky flag.
module node_interface
    import config_pkg::*;
#(
    parameter int NODE_ID = 0,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  packet_t     gen_data,
    input  logic        gen_val,
    output logic        gen_rdy,
    output packet_t     net_data,
    output logic        net_val,
    input  logic        net_en,
    input  packet_t     ej_data,
    input  logic        ej_val,
    output logic [15:0] tx_count,
    output logic [15:0] rx_count,
    output logic [31:0] lat_sum,
    output logic        err_dest
);

    localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);

    logic [TS_W-1:0]  cycle;
    logic             fifo_full;
    logic             fifo_empty;
    logic [PKT_W-1:0] fifo_head;
    logic             push;
    logic             pop;
    packet_t          stamped;
    logic [TS_W-1:0]  latency;
    logic [32:0]      lat_next;
    logic             unused_fields;

    // Fields replaced by stamping or never inspected on ejection.
    assign unused_fields = ^{gen_data.src, gen_data.timestamp,
                             ej_data.src, ej_data.payload};

    // Held low during reset so nothing is queued while state is cleared.
    assign gen_rdy = !fifo_full && !reset;
    assign push    = gen_val && gen_rdy;
    assign net_val = !fifo_empty;
    assign pop     = net_val && net_en;

    always_comb begin
        stamped           = gen_data;
        stamped.src       = MY_ID;
        stamped.timestamp = cycle;
    end

    assign net_data = fifo_empty ? '0 : packet_t'(fifo_head);

    sync_fifo #(
        .WIDTH(PKT_W),
        .DEPTH(DEPTH)
    ) u_inj_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (push),
        .wr_data(stamped),
        .pop    (pop),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Modulo-2^16 difference tolerates one wrap of the cycle counter.
    assign latency  = cycle - ej_data.timestamp;
    assign lat_next = {1'b0, lat_sum} + {17'b0, latency};

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle    <= '0;
            tx_count <= '0;
            rx_count <= '0;
            lat_sum  <= '0;
            err_dest <= 1'b0;
        end else begin
            cycle <= cycle + 1'b1;
            if (pop && (tx_count != 16'hFFFF)) begin
                tx_count <= tx_count + 1'b1;
            end
            if (ej_val) begin
                if (rx_count != 16'hFFFF) begin
                    rx_count <= rx_count + 1'b1;
                end
                lat_sum <= lat_next[32] ? 32'hFFFF_FFFF : lat_next[31:0];
                if (ej_data.dest != MY_ID) begin
                    err_dest <= 1'b1;
                end
            end
        end
    end

endmodule
